rob_result_arbiter: RTL

//  Transmit side of the ROB result bus: collects completions from NUM_FU execution units.

---
 rtl/rob_pkg.sv | 21 ++
 rtl/rob_result_fifo.sv | 56 +++++
 rtl/rob_result_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// rob_pkg: types and constants shared between the ROB and the result arbiter.
//   ROBID_W     robid width carried on the result bus
//   RES_DATA_W  result value / branch target width
//   FLAG_WB     flags bit marking a register writeback
//   FLAG_BR     flags bit marking a branch result
//   rob_result_t  one completion as it travels from a unit to the ROB
package rob_pkg;

   localparam int ROBID_W    = 4;
   localparam int RES_DATA_W = 8;
   localparam int FLAG_WB    = 7;
   localparam int FLAG_BR    = 5;

   typedef struct packed {
      logic [ROBID_W-1:0]    robid;
      logic [7:0]            flags;
      logic [7:0]            wbs;
      logic [RES_DATA_W-1:0] value;
   } rob_result_t;

endpackage

// File: rtl/rob_result_fifo.sv
// rob_result_fifo: small per-unit completion buffer.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_push         write i_data (caller guarantees !o_full)
//   i_pop          drop the head entry (caller guarantees !o_empty)
//   i_flush        discard all entries; dominates push/pop
//   i_data         entry to write
//   o_full/o_empty occupancy flags derived from the entry count
//   o_head         current head entry, read combinationally
module rob_result_fifo
   import rob_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_push,
   input  logic        i_pop,
   input  logic        i_flush,
   input  rob_result_t i_data,
   output logic        o_full,
   output logic        o_empty,
   output rob_result_t o_head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   rob_result_t   r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + AW'(1);
         end
         if (i_pop) begin
            r_rd <= r_rd + AW'(1);
         end
         // push and pop together leave the count unchanged
         r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
      end
   end

   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/rob_result_arbiter.sv
// rob_result_arbiter: transmit side of the ROB result bus. Buffers completions
// from NUM_FU units in per-unit FIFOs and forwards one per cycle, round-robin,
// to the ROB, which cannot stall.
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_fu_valid/o_fu_ready  per-unit completion handshake
//   i_fu_robid/flags/wbs/value  per-unit completion payload, unit i at slice i
//   i_branch_transmit    redirect from the ROB; discards everything pending
//   o_rob_transmit       one-cycle pulse per forwarded result
//   o_robid/flags/wbs/value  forwarded result, held between pulses
module rob_result_arbiter
   import rob_pkg::*;
#(
   parameter int NUM_FU     = 4,
   parameter int FIFO_DEPTH = 2,
   parameter int ID_W       = ROBID_W,
   parameter int DATA_W     = RES_DATA_W
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NUM_FU-1:0]        i_fu_valid,
   output logic [NUM_FU-1:0]        o_fu_ready,
   input  logic [NUM_FU*ID_W-1:0]   i_fu_robid,
   input  logic [NUM_FU*8-1:0]      i_fu_flags,
   input  logic [NUM_FU*8-1:0]      i_fu_wbs,
   input  logic [NUM_FU*DATA_W-1:0] i_fu_value,
   input  logic                     i_branch_transmit,
   output logic                     o_rob_transmit,
   output logic [ID_W-1:0]          o_robid,
   output logic [7:0]               o_flags,
   output logic [7:0]               o_wbs,
   output logic [DATA_W-1:0]        o_value
);

   localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   logic [NUM_FU-1:0] w_full;
   logic [NUM_FU-1:0] w_empty;
   logic [NUM_FU-1:0] w_ready;
   logic [NUM_FU-1:0] w_push;
   logic [NUM_FU-1:0] w_pop;
   logic [NUM_FU-1:0] w_req;
   logic [NUM_FU-1:0] w_req_hi;
   logic [PTR_W-1:0]  w_win;
   logic              w_any;
   rob_result_t       w_in   [NUM_FU];
   rob_result_t       w_head [NUM_FU];

   logic [PTR_W-1:0]  r_rr;
   logic              r_tx;
   rob_result_t       r_res;

   assign w_ready    = i_rst ? '0 : ~w_full;
   assign o_fu_ready = w_ready;
   // an accept during a flush cycle is dropped rather than buffered
   assign w_push     = i_fu_valid & w_ready & {NUM_FU{~i_branch_transmit}};

   for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
      assign w_in[g] = '{robid: i_fu_robid[g*ID_W +: ID_W],
                         flags: i_fu_flags[g*8 +: 8],
                         wbs:   i_fu_wbs[g*8 +: 8],
                         value: i_fu_value[g*DATA_W +: DATA_W]};

      assign w_pop[g] = w_any & (w_win == PTR_W'(g)) & ~i_branch_transmit;

      rob_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_push  (w_push[g]),
         .i_pop   (w_pop[g]),
         .i_flush (i_branch_transmit),
         .i_data  (w_in[g]),
         .o_full  (w_full[g]),
         .o_empty (w_empty[g]),
         .o_head  (w_head[g])
      );
   end

   // Rotate-mask find-first: lowest requester at or above r_rr wins; if none
   // there, the search wraps to the lowest requester overall.
   always_comb begin
      w_req    = ~w_empty;
      w_req_hi = '0;
      w_win    = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         w_req_hi[i] = w_req[i] && (i >= int'(r_rr));
      end
      for (int i = NUM_FU - 1; i >= 0; i--) begin
         if (w_req[i]) w_win = PTR_W'(i);
      end
      for (int i = NUM_FU - 1; i >= 0; i--) begin
         if (w_req_hi[i]) w_win = PTR_W'(i);
      end
   end

   assign w_any = |w_req;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rr  <= '0;
         r_tx  <= 1'b0;
         r_res <= '0;
      end else if (i_branch_transmit) begin
         r_tx <= 1'b0;
      end else if (w_any) begin
         r_tx  <= 1'b1;
         r_res <= w_head[w_win];
         r_rr  <= (w_win == PTR_W'(NUM_FU - 1)) ? '0 : w_win + PTR_W'(1);
      end else begin
         r_tx <= 1'b0;
      end
   end

   assign o_rob_transmit = r_tx;
   assign o_robid        = r_res.robid;
   assign o_flags        = r_res.flags;
   assign o_wbs          = r_res.wbs;
   assign o_value        = r_res.value;

endmodule
